dac_frame_spi_tx: RTL and testbench
===================================

// Module: dac_frame_spi_tx
// PURPOSE
//  Downstream stage of wave_generator: accepts 8-bit samples on a single-cycle valid strobe, buffers them
//  in a small FIFO and serialises each as a 16-bit DAC command frame over SPI mode 0 (CPOL=0, CPHA=0).
//  Decouples the generator's sample rate from the SPI frame rate and flags dropped samples. Registered outputs only.
// PARAMETERS
//  FIFO_AW   2        FIFO address width; depth = 2**FIFO_AW (4 entries)
//  CLK_DIV   2        SCLK half-period in clk_i cycles; legal range 1..255
//  CMD       4'b0011  command nibble placed in frame bits [15:12]
// PORTS
//  clk_i                   in   1         single system clock; all logic on rising edge
//  rst_i                   in   1         synchronous, active-high reset
//  data_i                  in   8         sample from wave_generator
//  data_in_valid_strobe_i  in   1         1-cycle strobe; data_i is captured on that clk_i edge
//  spi_clk_o               out  1         SPI clock, idle low
//  spi_mosi_o              out  1         SPI data, MSB first, changes only while spi_clk_o low
//  spi_cs_o                out  1         chip select, active low
//  busy_o                  out  1         1 whenever FSM is not IDLE
//  overflow_o              out  1         sticky: a strobe arrived while FIFO full; cleared only by rst_i
//  fill_level_o            out  FIFO_AW+1 current FIFO occupancy, 0..2**FIFO_AW
// BEHAVIOUR
//  Reset (rst_i=1 at a clk_i edge): spi_cs_o=1, spi_clk_o=0, spi_mosi_o=0, busy_o=0, overflow_o=0, fill_level_o=0,
//   FIFO pointers cleared, FSM->IDLE. Mid-frame reset aborts the frame: cs high and sclk low from the next cycle.
//  FIFO: strobe with fill<DEPTH -> write, fill+1. Strobe with fill==DEPTH -> sample dropped, overflow_o<=1.
//   Pointers wrap modulo DEPTH. Pop happens only in IDLE. Write+pop in same cycle -> fill unchanged.
//   Write into a full FIFO in the cycle it is popped is accepted (no overflow).
//  Frame word: {CMD, data[7:0], 4'b0000}, shifted out MSB first.
//  FSM (divider counter div counts 0..CLK_DIV-1; bit counter bcnt 15..0):
//   IDLE : cs=1, sclk=0. If fill!=0: pop, shreg<=frame, bcnt<=15, div<=0, cs<=0, mosi<=frame[15] -> LOW.
//   LOW  : sclk=0 for CLK_DIV cycles; at end sclk<=1 -> HIGH (slave samples on this rising edge).
//   HIGH : sclk=1 for CLK_DIV cycles; at end sclk<=0; if bcnt==0 -> HOLD,
//          else shreg<<=1, mosi<=next bit, bcnt-=1 -> LOW.
//   HOLD : cs=0, sclk=0 for CLK_DIV cycles; at end cs<=1, mosi<=0 -> GAP.
//   GAP  : cs=1 for CLK_DIV cycles (min cs-high time) -> IDLE.
//  Timing: frame start (IDLE pop) to next possible pop = 34*CLK_DIV+1 cycles (69 at CLK_DIV=2).
//   cs low for 33*CLK_DIV cycles; exactly 16 rising sclk edges per frame; mosi stable >= CLK_DIV cycles before each.
//  Latency: strobe at edge t into empty FIFO, FSM idle -> fill=1 after t, pop at t+1, cs_o low after edge t+1.
//  Strobes during a frame are buffered; frame in progress is never altered by FIFO activity.
//  busy_o=0 only in IDLE; strobe input ignored only by overflow rule above, never by FSM state.
//  fill_level_o width FIFO_AW+1 so the value DEPTH is representable.
// TESTING
//  1. Reset, single strobe data_i=8'hA5, CLK_DIV=2 -> captured MOSI on 16 sclk rises = 16'h3A50; cs low 66 cycles; overflow_o=0.
//  2. Six back-to-back strobes 8'h01..8'h06 while idle -> 8'h06 dropped, overflow_o=1, frames 8'h01..8'h05 in order, fill_level_o peaks at 4.
//  3. Strobe each 69 cycles for 10 samples -> no overflow, fill_level_o never exceeds 1, cs high exactly 3 cycles between frames (GAP+IDLE).
//  4. Assert rst_i during bit 7 of a frame with 2 queued samples -> next cycle cs_o=1, spi_clk_o=0, fill_level_o=0, overflow_o=0, no further frames.
//  5. CLK_DIV=1, strobe 8'hFF -> frame 16'h3FF0, sclk period 2 cycles, frame-to-frame period 35 cycles.
//  6. FIFO full and strobe in the IDLE pop cycle -> sample accepted, fill stays 4, overflow_o stays 0.

Source files
------------

// File: rtl/dac_frame_spi_tx.sv
// Sample FIFO feeding an SPI mode-0 serialiser: each 8-bit sample becomes a
// 16-bit DAC command frame {CMD, sample, 4'b0000}, sent MSB first.
module dac_frame_spi_tx #(
    parameter int unsigned FIFO_AW = 2,
    parameter int unsigned CLK_DIV = 2,
    parameter logic [3:0]  CMD     = 4'b0011
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       data_i,
    input  logic             data_in_valid_strobe_i,
    output logic             spi_clk_o,
    output logic             spi_mosi_o,
    output logic             spi_cs_o,
    output logic             busy_o,
    output logic             overflow_o,
    output logic [FIFO_AW:0] fill_level_o
);

    localparam int unsigned        DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL     = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   FILL_ONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [7:0]         DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [15:0]        shreg;
    logic [3:0]         bcnt;
    logic [7:0]         div;

    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               div_end;
    logic [15:0]        frame;

    // A strobe into a full FIFO is still accepted when the same edge pops.
    always_comb begin
        fifo_full = (fill_level_o == FULL);
        pop       = (state == S_IDLE) && (fill_level_o != '0);
        push      = data_in_valid_strobe_i && (!fifo_full || pop);
        div_end   = (div == DIV_LAST);
        frame     = {CMD, mem[rd_ptr], 4'b0000};
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill_level_o <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                fill_level_o <= fill_level_o + FILL_ONE;
            end else if (!push && pop) begin
                fill_level_o <= fill_level_o - FILL_ONE;
            end
            if (data_in_valid_strobe_i && !push) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // shreg holds the bits still to be sent, so MOSI always comes from bit 15.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            spi_cs_o   <= 1'b1;
            spi_clk_o  <= 1'b0;
            spi_mosi_o <= 1'b0;
            busy_o     <= 1'b0;
            shreg      <= '0;
            bcnt       <= '0;
            div        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg      <= {frame[14:0], 1'b0};
                        spi_mosi_o <= frame[15];
                        bcnt       <= 4'd15;
                        div        <= '0;
                        spi_cs_o   <= 1'b0;
                        busy_o     <= 1'b1;
                        state      <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (div_end) begin
                        div       <= '0;
                        spi_clk_o <= 1'b1;
                        state     <= S_HIGH;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (div_end) begin
                        div       <= '0;
                        spi_clk_o <= 1'b0;
                        if (bcnt == 4'd0) begin
                            state <= S_HOLD;
                        end else begin
                            spi_mosi_o <= shreg[15];
                            shreg      <= shreg << 1;
                            bcnt       <= bcnt - 4'd1;
                            state      <= S_LOW;
                        end
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (div_end) begin
                        div        <= '0;
                        spi_cs_o   <= 1'b1;
                        spi_mosi_o <= 1'b0;
                        state      <= S_GAP;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                S_GAP: begin
                    if (div_end) begin
                        div    <= '0;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        div <= div + 8'd1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    spi_cs_o   <= 1'b1;
                    spi_clk_o  <= 1'b0;
                    spi_mosi_o <= 1'b0;
                    busy_o     <= 1'b0;
                    div        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_spi_tx.sv
// Bench for dac_frame_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1), an SPI
// frame monitor, vector table, hand sequences and a queue-based random model.
module tb_dac_frame_spi_tx;

    localparam logic [3:0] CMD = 4'b0011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [2];
    logic       stb  [2];
    logic [7:0] din  [2];
    logic       sclk [2];
    logic       mosi [2];
    logic       cs   [2];
    logic       busy [2];
    logic       ovf  [2];
    logic [2:0] fill [2];

    dac_frame_spi_tx #(.FIFO_AW(2), .CLK_DIV(2), .CMD(CMD)) u_dut_div2 (
        .clk_i(clk), .rst_i(rst[0]), .data_i(din[0]), .data_in_valid_strobe_i(stb[0]),
        .spi_clk_o(sclk[0]), .spi_mosi_o(mosi[0]), .spi_cs_o(cs[0]),
        .busy_o(busy[0]), .overflow_o(ovf[0]), .fill_level_o(fill[0])
    );

    dac_frame_spi_tx #(.FIFO_AW(2), .CLK_DIV(1), .CMD(CMD)) u_dut_div1 (
        .clk_i(clk), .rst_i(rst[1]), .data_i(din[1]), .data_in_valid_strobe_i(stb[1]),
        .spi_clk_o(sclk[1]), .spi_mosi_o(mosi[1]), .spi_cs_o(cs[1]),
        .busy_o(busy[1]), .overflow_o(ovf[1]), .fill_level_o(fill[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame monitor: captures completed frames and timing per instance.
    int         cyc = 0;
    logic [15:0] mon_frame [2][256];
    int         mon_cslow [2][256];
    int         mon_gap   [2][256];
    int         mon_span  [2][256];
    int         mon_start [2][256];
    int         mon_n     [2] = '{0, 0};
    int         mon_abort [2] = '{0, 0};
    int         mon_viol  [2] = '{0, 0};
    logic       prev_sclk [2] = '{1'b0, 1'b0};
    logic       prev_cs   [2] = '{1'b1, 1'b1};
    logic       prev_mosi [2] = '{1'b0, 1'b0};
    logic [15:0] sh       [2];
    int         bits [2], cslow [2], cshigh [2], mosi_age [2];
    int         first_rise [2], last_rise [2], cur_gap [2], cur_start [2];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            int dk;
            dk = (k == 0) ? 2 : 1;
            if (mosi[k] !== prev_mosi[k]) begin
                mosi_age[k] = 1;
                if (sclk[k] === 1'b1) mon_viol[k]++;
            end else begin
                mosi_age[k]++;
            end
            if (cs[k] === 1'b0 && prev_cs[k] === 1'b1) begin
                cur_gap[k]   = cshigh[k];
                cur_start[k] = cyc;
                bits[k]      = 0;
                sh[k]        = '0;
                cslow[k]     = 0;
            end
            if (cs[k] === 1'b1 && prev_cs[k] === 1'b0) begin
                if (bits[k] == 16 && mon_n[k] < 256) begin
                    mon_frame[k][mon_n[k]] = sh[k];
                    mon_cslow[k][mon_n[k]] = cslow[k];
                    mon_gap[k][mon_n[k]]   = cur_gap[k];
                    mon_span[k][mon_n[k]]  = last_rise[k] - first_rise[k];
                    mon_start[k][mon_n[k]] = cur_start[k];
                    mon_n[k]++;
                end else begin
                    mon_abort[k]++;
                end
                cshigh[k] = 0;
            end
            if (cs[k] === 1'b1) cshigh[k]++;
            if (cs[k] === 1'b0) cslow[k]++;
            if (sclk[k] === 1'b1 && prev_sclk[k] === 1'b0) begin
                if (cs[k] !== 1'b0) begin
                    mon_viol[k]++;
                end else begin
                    if (mosi_age[k] < dk + 1) mon_viol[k]++;
                    sh[k] = {sh[k][14:0], mosi[k]};
                    if (bits[k] == 0) first_rise[k] = cyc;
                    last_rise[k] = cyc;
                    bits[k]++;
                end
            end
            prev_sclk[k] = sclk[k];
            prev_cs[k]   = cs[k];
            prev_mosi[k] = mosi[k];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic do_reset(input int k);
        rst[k] = 1'b1;
        repeat (2) @(negedge clk);
        rst[k] = 1'b0;
    endtask

    task automatic pulse(input int k, input logic [7:0] d);
        din[k] = d;
        stb[k] = 1'b1;
        @(negedge clk);
        stb[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget, input string tag);
        int n;
        n = 0;
        while (!(busy[k] === 1'b0 && fill[k] === 3'd0 && cs[k] === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < budget), 1);
        @(negedge clk);
    endtask

    task automatic run_random(input int k, input int ncyc);
        int          dk;
        int          next_pop;
        int          base;
        int          mism;
        logic        m_ovf;
        logic [7:0]  q[$];
        logic [15:0] expf[$];
        dk       = (k == 0) ? 2 : 1;
        next_pop = 0;
        mism     = 0;
        m_ovf    = 1'b0;
        do_reset(k);
        base = mon_n[k];
        for (int e = 0; e < ncyc; e++) begin
            logic       s;
            logic [7:0] d;
            int         sz;
            int         thr;
            logic       p;
            case ((e / 150) % 3)
                0:       thr = 70;
                1:       thr = 2;
                default: thr = 25;
            endcase
            s = ($urandom_range(0, 99) < thr);
            d = 8'($urandom);
            stb[k] = s;
            din[k] = d;
            sz = q.size();
            p  = (e >= next_pop) && (sz != 0);
            if (p) begin
                expf.push_back({CMD, q.pop_front(), 4'h0});
                next_pop = e + 34 * dk + 1;
            end
            if (s) begin
                if (sz < 4 || p) q.push_back(d);
                else m_ovf = 1'b1;
            end
            @(negedge clk);
            if (fill[k] !== 3'(q.size()) || ovf[k] !== m_ovf) mism++;
        end
        stb[k] = 1'b0;
        while (q.size() != 0) expf.push_back({CMD, q.pop_front(), 4'h0});
        check("rand_track_mismatch_cycles", mism, 0);
        check("rand_ovf_final", ovf[k], m_ovf);
        wait_idle(k, 5 * (34 * dk + 1) + 20, "rand");
        check("rand_nframes", mon_n[k] - base, expf.size());
        for (int i = 0; i < expf.size() && base + i < 256; i++) begin
            check("rand_frame", mon_frame[k][base + i], expf[i]);
            check("rand_cslow", mon_cslow[k][base + i], 33 * dk);
        end
    endtask

    typedef struct {
        logic [7:0]  d;
        logic [15:0] frame;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   base, peak, n, lows, rises, ab;
        logic prev;
        logic [7:0] exp3 [10];

        vecs[0] = '{8'hA5, 16'h3A50};
        vecs[1] = '{8'h00, 16'h3000};
        vecs[2] = '{8'hFF, 16'h3FF0};
        vecs[3] = '{8'h5A, 16'h35A0};
        vecs[4] = '{8'h80, 16'h3800};
        vecs[5] = '{8'h01, 16'h3010};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            stb[k] = 1'b0;
            din[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_cs", cs[0], 1);
        check("rst_sclk", sclk[0], 0);
        check("rst_mosi", mosi[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_ovf", ovf[0], 0);
        check("rst_fill", fill[0], 0);
        check("rst_cs_div1", cs[1], 1);
        check("rst_sclk_div1", sclk[1], 0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // Single-frame vectors, including latency from strobe to cs low.
        for (int i = 0; i < 6; i++) begin
            base = mon_n[0];
            pulse(0, vecs[i].d);
            check("lat_fill1", fill[0], 1);
            check("lat_cs_still_high", cs[0], 1);
            @(negedge clk);
            check("lat_cs_low", cs[0], 0);
            check("lat_busy", busy[0], 1);
            check("lat_fill0", fill[0], 0);
            wait_idle(0, 200, "vec");
            check("vec_nframes", mon_n[0] - base, 1);
            check("vec_frame", mon_frame[0][base], vecs[i].frame);
            check("vec_cslow", mon_cslow[0][base], 66);
            check("vec_span", mon_span[0][base], 60);
            check("vec_ovf", ovf[0], 0);
        end

        // Six back-to-back strobes from idle: the sixth is dropped.
        do_reset(0);
        base = mon_n[0];
        peak = 0;
        for (int i = 1; i <= 6; i++) begin
            din[0] = 8'(i);
            stb[0] = 1'b1;
            @(negedge clk);
            if (int'(fill[0]) > peak) peak = int'(fill[0]);
        end
        stb[0] = 1'b0;
        check("burst_fill_full", fill[0], 4);
        check("burst_ovf", ovf[0], 1);
        wait_idle(0, 5 * 69 + 40, "burst");
        check("burst_nframes", mon_n[0] - base, 5);
        for (int i = 0; i < 5; i++)
            check("burst_frame", mon_frame[0][base + i], {CMD, 8'(i + 1), 4'h0});
        check("burst_peak", peak, 4);
        check("burst_ovf_sticky", ovf[0], 1);

        // Full FIFO with a strobe landing on the idle pop edge.
        do_reset(0);
        check("rst_clears_ovf", ovf[0], 0);
        base = mon_n[0];
        din[0] = 8'h11;
        stb[0] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            din[0] = 8'(i * 16 + i);
            @(negedge clk);
        end
        stb[0] = 1'b0;
        check("full_fill", fill[0], 4);
        check("full_ovf", ovf[0], 0);
        n = 0;
        while (busy[0] !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("full_idle_wait", 32'(n < 200), 1);
        check("full_idle_fill", fill[0], 4);
        pulse(0, 8'h66);
        check("popcycle_fill", fill[0], 4);
        check("popcycle_ovf", ovf[0], 0);
        check("popcycle_busy", busy[0], 1);
        wait_idle(0, 6 * 69 + 40, "popcycle");
        check("popcycle_nframes", mon_n[0] - base, 6);
        check("popcycle_first", mon_frame[0][base], 16'h3110);
        check("popcycle_last", mon_frame[0][base + 5], 16'h3660);

        // One strobe every 69 cycles: never more than one entry buffered.
        do_reset(0);
        base = mon_n[0];
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            exp3[i] = 8'($urandom);
            pulse(0, exp3[i]);
            if (int'(fill[0]) > peak) peak = int'(fill[0]);
            repeat (68) begin
                @(negedge clk);
                if (int'(fill[0]) > peak) peak = int'(fill[0]);
            end
        end
        wait_idle(0, 200, "paced");
        check("paced_nframes", mon_n[0] - base, 10);
        for (int i = 0; i < 10; i++) begin
            check("paced_frame", mon_frame[0][base + i], {CMD, exp3[i], 4'h0});
            if (i > 0) check("paced_gap", mon_gap[0][base + i], 3);
        end
        check("paced_peak", peak, 1);
        check("paced_ovf", ovf[0], 0);

        // Reset during bit 7 with two samples queued.
        do_reset(0);
        base = mon_n[0];
        ab   = mon_abort[0];
        stb[0] = 1'b1;
        din[0] = 8'hC1;
        @(negedge clk);
        din[0] = 8'hC2;
        @(negedge clk);
        din[0] = 8'hC3;
        @(negedge clk);
        stb[0] = 1'b0;
        check("abort_queued", fill[0], 2);
        rises = 0;
        n     = 0;
        prev  = sclk[0];
        while (rises < 9 && n < 500) begin
            @(negedge clk);
            n++;
            if (sclk[0] === 1'b1 && prev === 1'b0) rises++;
            prev = sclk[0];
        end
        check("abort_reach_bit7", 32'(n < 500), 1);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("abort_cs", cs[0], 1);
        check("abort_sclk", sclk[0], 0);
        check("abort_fill", fill[0], 0);
        check("abort_ovf", ovf[0], 0);
        check("abort_busy", busy[0], 0);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (cs[0] !== 1'b1) lows++;
        end
        check("abort_cs_stays_high", lows, 0);
        check("abort_nframes", mon_n[0] - base, 0);
        check("abort_count", mon_abort[0] - ab, 1);

        // CLK_DIV=1: two back-to-back frames.
        do_reset(1);
        base = mon_n[1];
        stb[1] = 1'b1;
        din[1] = 8'hFF;
        @(negedge clk);
        din[1] = 8'h00;
        @(negedge clk);
        stb[1] = 1'b0;
        wait_idle(1, 150, "div1");
        check("div1_nframes", mon_n[1] - base, 2);
        check("div1_frame0", mon_frame[1][base], 16'h3FF0);
        check("div1_frame1", mon_frame[1][base + 1], 16'h3000);
        check("div1_span", mon_span[1][base], 30);
        check("div1_cslow", mon_cslow[1][base], 33);
        check("div1_period", mon_start[1][base + 1] - mon_start[1][base], 35);

        run_random(0, 1500);
        run_random(1, 1000);

        check("spi_rules_div2", mon_viol[0], 0);
        check("spi_rules_div1", mon_viol[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
